grp_buf_arbiter: RTL and testbench
==================================

Name: grp_buf_arbiter

Overview:
- Round-robin arbiter granting exclusive access to the shared group-buffer write/read-back port: the muxed write data, address, write enable, old-word read address and read enable.
- Requesters are LCB packers 1-4 (indices 0-3) and the MCM packer (index 4).
- Sits between the requesters' busy/request lines and the port multiplexer. Drives the one-hot grant plus a binary select for the mux.
- Revokes a grant on hold timeout, or when the frame former swaps the ping-pong buffers mid-transaction.

Parameters:
- N, 5, number of requesters (2..8).
- SELW, 3, width of sel output; must satisfy 2^SELW >= N.
- MAX_HOLD, 1024, maximum consecutive grant cycles before forced revoke (>= 2).
- HCW, 11, hold counter width; must satisfy 2^HCW > MAX_HOLD.

Ports:
- clk  in  1  system clock (80 MHz domain)
- reset  in  1  synchronous, active-high reset
- iReq  in  N  per-requester access request; level, held for the whole transaction
- iDone  in  N  per-requester release strobe; only the bit of the granted requester is honoured
- iSwitch  in  1  buffer-swap flag from frame former, already synchronous to clk
- oGnt  out  N  one-hot grant, registered
- oSel  out  SELW  binary index of granted requester; holds last value when no grant
- oValid  out  1  high while any grant is active (OR of oGnt)
- oAbort  out  N  one-cycle pulse to a requester whose grant was revoked
- oTmoCnt  out  8  saturating count of timeout revokes
- oSwpCnt  out  8  saturating count of swap revokes

Behaviour:
- Reset (synchronous, any state):
  - All outputs go to 0 and the FSM goes to IDLE.
  - RR pointer = 0, hold counter = 0, swD (registered iSwitch) = iSwitch.
- Swap detect: swTog = iSwitch ^ swD. swD updates every cycle.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If swTog = 1, no grant is issued this cycle (guard).
  - Otherwise search iReq starting at ptr, ascending, wrapping at N-1 -> 0. The first set bit k wins.
  - On a winner: next cycle oGnt = 1<<k, oSel = k, oValid = 1, ptr = (k+1) mod N, hold = 1, go to GRANT.
  - Latency from iReq to oGnt is 1 cycle. With no request, stay in IDLE.
- GRANT, evaluated each cycle with s = oSel:
  - Release when iDone[s] = 1 or iReq[s] = 0: next cycle oGnt = 0, oValid = 0, go to GAP, no abort.
  - Otherwise, if swTog = 1: revoke, meaning oGnt = 0 and oAbort[s] = 1 for one cycle (same cycle oGnt falls). oSwpCnt += 1 (saturate 255). Go to GAP.
  - Otherwise, if hold = MAX_HOLD: revoke with oAbort[s], oTmoCnt += 1 (saturate 255), go to GAP.
  - Otherwise hold += 1.
- Simultaneous-event priority: release > swap > timeout. No counter increments when a release coincides with either. A swap coinciding with timeout counts only in oSwpCnt.
- GAP:
  - Exactly one cycle with oGnt = 0 and oAbort = 0, then IDLE.
  - Requests are not sampled in GAP. Minimum dead time between consecutive grants is 2 cycles (GAP + IDLE arbitration).
- Invariants:
  - oGnt is always zero or one-hot.
  - oAbort is asserted only for the index just revoked, and never on a normal release.
  - iDone bits of non-granted requesters are ignored.
  - Requests issued while another requester holds the grant wait. Starvation bound: N grants.
- Pointer wrap: a grant to N-1 sets ptr = 0.
- oSel retains its last value in IDLE and GAP.

Test Plan:
- Reset, then iReq=5'b10001 held, each grant released with iDone after 3 cycles -> grant order 0,4,0,4; oGnt rises 1 cycle after arbitration. Gap between oGnt falling and the next rising is 2 cycles.
- iReq=5'b11111 continuously, release after 1 cycle -> grants cycle 0,1,2,3,4,0; oSel follows. oGnt is never multi-hot.
- Single requester 2 never releases, MAX_HOLD=1024 -> oGnt[2] high exactly 1024 cycles, then oAbort=5'b00100 for 1 cycle and oTmoCnt=1. Re-grant to 2 occurs 2 cycles later.
- Requester 1 granted, iSwitch toggles at hold=10 -> next cycle oGnt=0, oAbort[1]=1, oSwpCnt=1. A toggle while in IDLE with pending iReq delays the grant by exactly 1 cycle.
- iDone[s] and swTog in the same cycle -> clean release, oAbort=0, both counters unchanged. iDone of a non-granted index -> no effect. 300 timeouts -> oTmoCnt saturates at 255.
- Assert reset during GRANT -> next cycle all outputs 0 and FSM in IDLE. With iReq=5'b01000 after reset release, the grant goes to 3 and the search starts from 0 (ptr=0).

Source files
------------

// File: rtl/grp_buf_arbiter.sv
// Round-robin arbiter for the shared group-buffer write/read-back port (LCB packers 0-3, MCM packer 4).
// Grants one requester at a time; revokes on hold timeout or on a ping-pong buffer swap.
module grp_buf_arbiter #(
    parameter int N        = 5,
    parameter int SELW     = 3,
    parameter int MAX_HOLD = 1024,
    parameter int HCW      = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    iReq,
    input  logic [N-1:0]    iDone,
    input  logic            iSwitch,
    output logic [N-1:0]    oGnt,
    output logic [SELW-1:0] oSel,
    output logic            oValid,
    output logic [N-1:0]    oAbort,
    output logic [7:0]      oTmoCnt,
    output logic [7:0]      oSwpCnt,
    output logic [1:0]      dbg_state
);
    // Handshake: a requester raises iReq and holds it; oGnt answers one cycle after arbitration.
    // The transaction ends when the owner pulses iDone or drops iReq, or when oAbort revokes it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state;
    logic [SELW-1:0] ptr;
    logic [HCW-1:0]  hold;
    logic            sw_d;
    logic            sw_tog;
    logic            win_found;
    logic [SELW-1:0] win_idx;
    logic [N-1:0]    win_gnt;
    logic [SELW-1:0] ptr_next;
    logic            own_req;
    logic            own_done;

    assign sw_tog    = iSwitch ^ sw_d;
    assign dbg_state = state;
    assign own_req   = iReq[oSel];
    assign own_done  = iDone[oSel];

    // Search upward from ptr, wrapping past N-1; the first requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_gnt   = '0;
        for (int i = 0; i < N; i++) begin
            int              cand;
            logic [SELW-1:0] idx;
            cand = int'(ptr) + i;
            if (cand >= N) cand = cand - N;
            idx = SELW'(cand);
            if (!win_found && iReq[idx]) begin
                win_found    = 1'b1;
                win_idx      = idx;
                win_gnt      = '0;
                win_gnt[idx] = 1'b1;
            end
        end
    end

    assign ptr_next = (win_idx == SELW'(N - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            hold    <= '0;
            sw_d    <= iSwitch;
            oGnt    <= '0;
            oSel    <= '0;
            oValid  <= 1'b0;
            oAbort  <= '0;
            oTmoCnt <= '0;
            oSwpCnt <= '0;
        end else begin
            sw_d   <= iSwitch;
            oAbort <= '0;
            case (state)
                IDLE: begin
                    // A buffer swap in this cycle suppresses arbitration for one cycle.
                    if (!sw_tog && win_found) begin
                        oGnt   <= win_gnt;
                        oSel   <= win_idx;
                        oValid <= 1'b1;
                        ptr    <= ptr_next;
                        hold   <= HCW'(1);
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (own_done || !own_req) begin
                        oGnt   <= '0;
                        oValid <= 1'b0;
                        state  <= GAP;
                    end else if (sw_tog || hold == HCW'(MAX_HOLD)) begin
                        oGnt   <= '0;
                        oValid <= 1'b0;
                        oAbort <= oGnt;
                        state  <= GAP;
                        // A swap landing on the timeout cycle is booked as a swap only.
                        if (sw_tog) begin
                            if (oSwpCnt != 8'hFF) oSwpCnt <= oSwpCnt + 8'd1;
                        end else begin
                            if (oTmoCnt != 8'hFF) oTmoCnt <= oTmoCnt + 8'd1;
                        end
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_grp_buf_arbiter.sv
// Self-checking bench for grp_buf_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level model of owner, hold time and dead time.
module tb_grp_buf_arbiter;
    localparam int N        = 5;
    localparam int SELW     = 3;
    localparam int MAX_HOLD = 64;
    localparam int HCW      = 7;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    iReq;
    logic [N-1:0]    iDone;
    logic            iSwitch;
    logic [N-1:0]    oGnt;
    logic [SELW-1:0] oSel;
    logic            oValid;
    logic [N-1:0]    oAbort;
    logic [7:0]      oTmoCnt;
    logic [7:0]      oSwpCnt;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the port, for how long, and how many dead cycles remain.
    int           m_owner = -1;
    int           m_held  = 0;
    int           m_dead  = 0;
    int           m_ptr   = 0;
    int           m_sel   = 0;
    int           m_tmo   = 0;
    int           m_swp   = 0;
    logic         m_sw    = 1'b0;
    logic [N-1:0] m_abort = '0;

    logic [N-1:0]    prev_gnt = '0;
    logic [SELW-1:0] exp_q[$];

    grp_buf_arbiter #(.N(N), .SELW(SELW), .MAX_HOLD(MAX_HOLD), .HCW(HCW)) dut (
        .clk      (clk),
        .reset    (reset),
        .iReq     (iReq),
        .iDone    (iDone),
        .iSwitch  (iSwitch),
        .oGnt     (oGnt),
        .oSel     (oSel),
        .oValid   (oValid),
        .oAbort   (oAbort),
        .oTmoCnt  (oTmoCnt),
        .oSwpCnt  (oSwpCnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit tog;
        tog     = (iSwitch != m_sw);
        m_sw    = iSwitch;
        m_abort = '0;
        if (reset) begin
            m_owner = -1; m_held = 0; m_dead = 0; m_ptr = 0;
            m_sel   = 0;  m_tmo  = 0; m_swp  = 0;
            return;
        end
        if (m_owner >= 0) begin
            if (iDone[m_owner] || !iReq[m_owner]) begin
                m_owner = -1; m_dead = 1;
            end else if (tog) begin
                m_abort[m_owner] = 1'b1;
                if (m_swp < 255) m_swp++;
                m_owner = -1; m_dead = 1;
            end else if (m_held == MAX_HOLD) begin
                m_abort[m_owner] = 1'b1;
                if (m_tmo < 255) m_tmo++;
                m_owner = -1; m_dead = 1;
            end else begin
                m_held++;
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else if (!tog) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (iReq[k]) begin
                    m_owner = k; m_sel = k; m_held = 1; m_ptr = (k + 1) % N;
                    break;
                end
            end
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic cyc();
        logic [N-1:0]    eg;
        logic [SELW-1:0] e;
        @(posedge clk);
        model_step();
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        n_checks++;
        if ({oGnt, oSel, oValid, oAbort, oTmoCnt, oSwpCnt} !==
            {eg, SELW'(m_sel), (m_owner >= 0), m_abort, 8'(m_tmo), 8'(m_swp)}) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t got gnt=%b sel=%0d valid=%b abort=%b tmo=%0d swp=%0d, expected gnt=%b sel=%0d valid=%b abort=%b tmo=%0d swp=%0d",
                     $time, oGnt, oSel, oValid, oAbort, oTmoCnt, oSwpCnt,
                     eg, m_sel, (m_owner >= 0), m_abort, m_tmo, m_swp);
        end
        n_checks++;
        if (!$onehot0(oGnt)) begin
            n_fail++;
            $display("FAIL gnt_onehot t=%0t got gnt=%b, expected zero or one-hot", $time, oGnt);
        end
        if (prev_gnt == '0 && oGnt != '0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (oSel !== e) begin
                n_fail++;
                $display("FAIL grant_order t=%0t got sel=%0d, expected %0d", $time, oSel, e);
            end
        end
        prev_gnt = oGnt;
    endtask

    task automatic wait_gnt(output int waited, output bit ok);
        waited = 0;
        ok     = 1'b1;
        while (oGnt == '0) begin
            if (waited >= 4 * MAX_HOLD) begin
                ok = 1'b0;
                n_checks++;
                n_fail++;
                $display("FAIL wait_gnt got no grant in %0d cycles, expected a grant", waited);
                return;
            end
            cyc();
            waited++;
        end
    endtask

    task automatic go_idle();
        iReq  = '0;
        iDone = '0;
        repeat (4) cyc();
    endtask

    // Serve n grants, each held hold_cyc cycles then released with iDone.
    task automatic serve(input int hold_cyc, input int n, input int first_lat, input int exp_gap);
        int w;
        bit ok;
        for (int g = 0; g < n; g++) begin
            wait_gnt(w, ok);
            if (!ok) return;
            n_checks++;
            if (w !== ((g == 0) ? first_lat : exp_gap)) begin
                n_fail++;
                $display("FAIL grant_latency grant %0d got %0d cycles, expected %0d", g, w,
                         (g == 0) ? first_lat : exp_gap);
            end
            repeat (hold_cyc - 1) cyc();
            iDone = oGnt;
            cyc();
            iDone = '0;
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({oGnt, oSel, oValid, oAbort, oTmoCnt, oSwpCnt, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL %s got gnt=%b sel=%0d valid=%b abort=%b tmo=%0d swp=%0d state=%0d, expected all 0",
                     name, oGnt, oSel, oValid, oAbort, oTmoCnt, oSwpCnt, dbg_state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        check_all_zero("reset_outputs");
        reset = 1'b0;
        cyc();
        check_all_zero("after_reset_idle");
    endtask

    task automatic test_two_req();
        exp_q = '{3'd0, 3'd4, 3'd0, 3'd4};
        iReq  = 5'b10001;
        serve(3, 4, 1, 2);
        go_idle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL two_req_order got %0d unmatched grants, expected 0", exp_q.size());
        end
    endtask

    task automatic test_all_req();
        exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        iReq  = 5'b11111;
        serve(1, 6, 1, 2);
        go_idle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL all_req_order got %0d unmatched grants, expected 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int w;
        int hi;
        bit ok;
        iReq = 5'b00100;
        wait_gnt(w, ok);
        if (!ok) return;
        hi = 1;
        while (oGnt != '0 && hi <= MAX_HOLD + 4) begin
            cyc();
            if (oGnt != '0) hi++;
        end
        n_checks++;
        if (hi !== MAX_HOLD) begin
            n_fail++;
            $display("FAIL timeout_hold got %0d grant cycles, expected %0d", hi, MAX_HOLD);
        end
        n_checks++;
        if (oAbort !== 5'b00100 || oTmoCnt !== 8'd1) begin
            n_fail++;
            $display("FAIL timeout_abort got abort=%b tmo=%0d, expected abort=00100 tmo=1", oAbort, oTmoCnt);
        end
        wait_gnt(w, ok);
        n_checks++;
        if (w !== 2 || oSel !== 3'd2) begin
            n_fail++;
            $display("FAIL timeout_regrant got %0d cycles sel=%0d, expected 2 cycles sel=2", w, oSel);
        end
        go_idle();
    endtask

    task automatic test_swap();
        int w;
        bit ok;
        iReq = 5'b00010;
        wait_gnt(w, ok);
        if (!ok) return;
        repeat (9) cyc();
        iSwitch = ~iSwitch;
        cyc();
        n_checks++;
        if (oGnt !== '0 || oAbort !== 5'b00010 || oSwpCnt !== 8'd1) begin
            n_fail++;
            $display("FAIL swap_revoke got gnt=%b abort=%b swp=%0d, expected gnt=00000 abort=00010 swp=1",
                     oGnt, oAbort, oSwpCnt);
        end
        go_idle();
        iReq    = 5'b00010;
        iSwitch = ~iSwitch;
        cyc();
        n_checks++;
        if (oGnt !== '0) begin
            n_fail++;
            $display("FAIL swap_idle_guard got gnt=%b, expected 00000", oGnt);
        end
        cyc();
        n_checks++;
        if (oGnt !== 5'b00010) begin
            n_fail++;
            $display("FAIL swap_idle_delayed got gnt=%b, expected 00010", oGnt);
        end
        go_idle();
    endtask

    task automatic test_done_swap();
        int         w;
        bit         ok;
        logic [7:0] t0;
        logic [7:0] s0;
        iReq = 5'b00001;
        wait_gnt(w, ok);
        if (!ok) return;
        t0    = oTmoCnt;
        s0    = oSwpCnt;
        iDone = 5'b11110;
        repeat (3) cyc();
        n_checks++;
        if (oGnt !== 5'b00001 || oAbort !== '0) begin
            n_fail++;
            $display("FAIL foreign_done got gnt=%b abort=%b, expected gnt=00001 abort=00000", oGnt, oAbort);
        end
        iDone   = 5'b00001;
        iSwitch = ~iSwitch;
        cyc();
        iDone = '0;
        n_checks++;
        if (oGnt !== '0 || oAbort !== '0 || oTmoCnt !== t0 || oSwpCnt !== s0) begin
            n_fail++;
            $display("FAIL done_vs_swap got gnt=%b abort=%b tmo=%0d swp=%0d, expected gnt=0 abort=0 tmo=%0d swp=%0d",
                     oGnt, oAbort, oTmoCnt, oSwpCnt, t0, s0);
        end
        go_idle();
    endtask

    task automatic test_random();
        int done_div;
        for (int c = 0; c < 4000; c++) begin
            done_div = (c < 2000) ? 5 : 150;
            for (int i = 0; i < N; i++) begin
                if (oGnt[i]) begin
                    iDone[i] = ($urandom_range(0, done_div) == 0);
                    if ($urandom_range(0, 199) == 0) iReq[i] = 1'b0;
                end else begin
                    iDone[i] = ($urandom_range(0, 9) == 0);
                    if ($urandom_range(0, 7) == 0) iReq[i] = ~iReq[i];
                end
            end
            if ($urandom_range(0, 59) == 0) iSwitch = ~iSwitch;
            reset = ($urandom_range(0, 1499) == 0);
            cyc();
        end
        reset = 1'b0;
        go_idle();
    endtask

    task automatic test_saturate();
        iReq = 5'b01000;
        repeat (300 * (MAX_HOLD + 2)) cyc();
        n_checks++;
        if (oTmoCnt !== 8'd255) begin
            n_fail++;
            $display("FAIL tmo_saturate got tmo=%0d, expected 255", oTmoCnt);
        end
        go_idle();
    endtask

    task automatic test_reset_in_grant();
        int w;
        bit ok;
        iReq = 5'b00010;
        wait_gnt(w, ok);
        if (!ok) return;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        check_all_zero("reset_in_grant");
        reset = 1'b0;
        iReq  = 5'b01000;
        wait_gnt(w, ok);
        n_checks++;
        if (w !== 1 || oSel !== 3'd3) begin
            n_fail++;
            $display("FAIL post_reset_grant got %0d cycles sel=%0d, expected 1 cycle sel=3", w, oSel);
        end
        go_idle();
        iReq = 5'b00010;
        wait_gnt(w, ok);
        if (!ok) return;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        iReq  = 5'b01001;
        wait_gnt(w, ok);
        n_checks++;
        if (oSel !== 3'd0) begin
            n_fail++;
            $display("FAIL post_reset_ptr got sel=%0d, expected 0", oSel);
        end
        go_idle();
    endtask

    initial begin
        reset   = 1'b1;
        iReq    = '0;
        iDone   = '0;
        iSwitch = 1'b0;
        test_reset();
        test_two_req();
        test_all_req();
        test_timeout();
        test_swap();
        test_done_swap();
        test_random();
        test_saturate();
        test_reset_in_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
